mem_access_stage: RTL and testbench

Parametrised, handshaked successor of the single-cycle memory stage. Sits between the EX/MEM and WB stages and contains the MEM/WB pipeline register. Supports:
- byte, halfword, word and (when DATA_W=64) doubleword loads and stores, with byte-lane strobes;
- sign/zero extension of loads;
- misalignment faulting;
- a req/ack data-memory interface with arbitrary wait states.

The stage stalls upstream while an access is outstanding and holds a completed result while downstream is stalled.

---
 rtl/mem_access_stage.sv | 218 +++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_stage.sv
// mem_access_stage: memory-access pipeline stage holding the MEM/WB register.
// Launches byte/half/word(/dword) loads and stores on a req/ack data-memory
// port, tolerates any number of wait states, extends load data, and faults
// misaligned or illegal-size accesses without touching memory.
// Ports:
//   clk, reset              clock; asynchronous active-high reset
//   enable                  downstream advance (0 freezes MEM/WB)
//   *_in_exmem              EX/MEM fields of the instruction being presented
//   stall_out               upstream must hold EX/MEM
//   dmem_*                  data-memory request/response interface
//   *_out_memwb             registered MEM/WB fields, plus fault flag
module mem_access_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned REG_AW = 4,
    parameter int unsigned OPC_W  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                valid_in_exmem,
    input  logic [ADDR_W-1:0]   pc_in_exmem,
    input  logic [DATA_W-1:0]   alu_result_in_exmem,
    input  logic [DATA_W-1:0]   write_data_in_exmem,
    input  logic [REG_AW-1:0]   Rd_in_exmem,
    input  logic [OPC_W-1:0]    opcode_in_exmem,
    input  logic                reg_write_en_in_exmem,
    input  logic                mem_read_en_in_exmem,
    input  logic                mem_write_en_in_exmem,
    input  logic                mem_to_reg_in_exmem,
    input  logic [1:0]          mem_size_in_exmem,
    input  logic                mem_signed_in_exmem,
    output logic                stall_out,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [ADDR_W-1:0]   dmem_addr,
    output logic [DATA_W/8-1:0] dmem_be,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic                dmem_ack,
    input  logic [DATA_W-1:0]   dmem_rdata,
    output logic                valid_out_memwb,
    output logic [ADDR_W-1:0]   pc_out_memwb,
    output logic [DATA_W-1:0]   alu_result_out_memwb,
    output logic [DATA_W-1:0]   mem_read_data_out_memwb,
    output logic [REG_AW-1:0]   Rd_out_memwb,
    output logic [OPC_W-1:0]    opcode_out_memwb,
    output logic                reg_write_en_out_memwb,
    output logic                mem_to_reg_out_memwb,
    output logic                fault_out_memwb
);
    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned LB = $clog2(NB);

    typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;
    state_e state_q;

    // Copy of the launched instruction, held stable for the whole access.
    logic [ADDR_W-1:0] pc_q, addr_q;
    logic [DATA_W-1:0] alu_q, wdata_q, res_q;
    logic [REG_AW-1:0] rd_q;
    logic [OPC_W-1:0]  opc_q;
    logic [NB-1:0]     be_q;
    logic [LB-1:0]     off_q;
    logic [1:0]        size_q;
    logic              we_q, sgn_q, rwe_q, m2r_q;

    // Decode of the presented instruction.
    logic              mem_op, size_ok, misaligned, fault_c;
    logic [LB-1:0]     off, size_mask;
    logic [NB-1:0]     st_be;
    logic [DATA_W-1:0] st_wdata;

    assign off        = alu_result_in_exmem[LB-1:0];
    assign mem_op     = valid_in_exmem & (mem_read_en_in_exmem | mem_write_en_in_exmem);
    assign size_ok    = (mem_size_in_exmem != 2'b11) || (DATA_W == 64);
    assign misaligned = |(off & size_mask);
    assign fault_c    = mem_op & (~size_ok | misaligned);

    always_comb begin
        case (mem_size_in_exmem)
            2'b00:   size_mask = '0;
            2'b01:   size_mask = LB'(1);
            2'b10:   size_mask = LB'(3);
            default: size_mask = LB'(7);
        endcase
    end

    // Lane i is enabled when it falls in the same S-byte group as the address;
    // each lane carries store byte (i mod S), replicating the data per group.
    always_comb begin
        st_be    = '0;
        st_wdata = '0;
        for (int i = 0; i < NB; i++) begin
            st_be[i] = ((LB'(i) & ~size_mask) == (off & ~size_mask));
            st_wdata[i*8 +: 8] = write_data_in_exmem[int'(LB'(i) & size_mask)*8 +: 8];
        end
    end

    // Load extraction from the response, using the latched size/offset.
    logic [DATA_W-1:0] shifted, load_ext, ret_data;
    logic              retire;

    assign shifted = dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        load_ext = shifted;
        case (size_q)
            2'b00: load_ext = {{(DATA_W-8){sgn_q & shifted[7]}}, shifted[7:0]};
            2'b01: load_ext = {{(DATA_W-16){sgn_q & shifted[15]}}, shifted[15:0]};
            2'b10: begin
                for (int b = 32; b < DATA_W; b++) load_ext[b] = sgn_q & shifted[31];
            end
            default: load_ext = shifted;
        endcase
    end

    // The held result is used from DONE; otherwise the live response.
    assign ret_data = (state_q == StDone) ? res_q : (we_q ? '0 : load_ext);
    assign retire   = enable & (((state_q == StReq) & dmem_ack) | (state_q == StDone));

    assign dmem_req   = (state_q == StReq);
    assign dmem_we    = dmem_req & we_q;
    assign dmem_be    = dmem_req ? be_q : '0;
    assign dmem_addr  = {addr_q[ADDR_W-1:LB], {LB{1'b0}}};
    assign dmem_wdata = wdata_q;

    assign stall_out = ((state_q == StIdle) & mem_op & ~fault_c)
                     | ((state_q == StReq) & ~dmem_ack)
                     | (state_q == StDone)
                     | (~enable & valid_in_exmem);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q                 <= StIdle;
            pc_q                    <= '0;
            addr_q                  <= '0;
            alu_q                   <= '0;
            wdata_q                 <= '0;
            res_q                   <= '0;
            rd_q                    <= '0;
            opc_q                   <= '0;
            be_q                    <= '0;
            off_q                   <= '0;
            size_q                  <= '0;
            we_q                    <= 1'b0;
            sgn_q                   <= 1'b0;
            rwe_q                   <= 1'b0;
            m2r_q                   <= 1'b0;
            valid_out_memwb         <= 1'b0;
            pc_out_memwb            <= '0;
            alu_result_out_memwb    <= '0;
            mem_read_data_out_memwb <= '0;
            Rd_out_memwb            <= '0;
            opcode_out_memwb        <= '0;
            reg_write_en_out_memwb  <= 1'b0;
            mem_to_reg_out_memwb    <= 1'b0;
            fault_out_memwb         <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enable) begin
                        if (mem_op && !fault_c) begin
                            pc_q    <= pc_in_exmem;
                            addr_q  <= ADDR_W'(alu_result_in_exmem);
                            alu_q   <= alu_result_in_exmem;
                            wdata_q <= st_wdata;
                            be_q    <= st_be;
                            off_q   <= off;
                            size_q  <= mem_size_in_exmem;
                            we_q    <= mem_write_en_in_exmem;
                            sgn_q   <= mem_signed_in_exmem;
                            rd_q    <= Rd_in_exmem;
                            opc_q   <= opcode_in_exmem;
                            rwe_q   <= reg_write_en_in_exmem;
                            m2r_q   <= mem_to_reg_in_exmem;
                            state_q <= StReq;
                        end else begin
                            // Non-mem op, bubble or faulting access: straight to MEM/WB.
                            valid_out_memwb         <= valid_in_exmem;
                            pc_out_memwb            <= pc_in_exmem;
                            alu_result_out_memwb    <= alu_result_in_exmem;
                            mem_read_data_out_memwb <= '0;
                            Rd_out_memwb            <= Rd_in_exmem;
                            opcode_out_memwb        <= opcode_in_exmem;
                            reg_write_en_out_memwb  <= valid_in_exmem & reg_write_en_in_exmem
                                                       & ~fault_c;
                            mem_to_reg_out_memwb    <= mem_to_reg_in_exmem;
                            fault_out_memwb         <= fault_c;
                        end
                    end
                end
                StReq: begin
                    if (dmem_ack) begin
                        res_q   <= we_q ? '0 : load_ext;
                        state_q <= enable ? StIdle : StDone;
                    end
                end
                StDone: begin
                    if (enable) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase

            if (retire) begin
                valid_out_memwb         <= 1'b1;
                pc_out_memwb            <= pc_q;
                alu_result_out_memwb    <= alu_q;
                mem_read_data_out_memwb <= ret_data;
                Rd_out_memwb            <= rd_q;
                opcode_out_memwb        <= opc_q;
                reg_write_en_out_memwb  <= rwe_q;
                mem_to_reg_out_memwb    <= m2r_q;
                fault_out_memwb         <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;
    logic        clk = 1'b0;
    logic        reset, enable, valid_in_exmem;
    logic [31:0] pc_in_exmem, alu_result_in_exmem, write_data_in_exmem;
    logic [3:0]  Rd_in_exmem;
    logic [4:0]  opcode_in_exmem;
    logic        reg_write_en_in_exmem, mem_read_en_in_exmem, mem_write_en_in_exmem;
    logic        mem_to_reg_in_exmem, mem_signed_in_exmem;
    logic [1:0]  mem_size_in_exmem;
    logic        stall_out, dmem_req, dmem_we, dmem_ack;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        valid_out_memwb, reg_write_en_out_memwb, mem_to_reg_out_memwb, fault_out_memwb;
    logic [31:0] pc_out_memwb, alu_result_out_memwb, mem_read_data_out_memwb;
    logic [3:0]  Rd_out_memwb;
    logic [4:0]  opcode_out_memwb;

    int n_total = 0;
    int n_pass  = 0;

    // Request fields seen during the last access, captured in its ack cycle.
    logic [31:0] obs_addr, obs_wdata;
    logic [3:0]  obs_be;
    logic        obs_we;

    mem_access_stage dut (
        .clk                     (clk),
        .reset                   (reset),
        .enable                  (enable),
        .valid_in_exmem          (valid_in_exmem),
        .pc_in_exmem             (pc_in_exmem),
        .alu_result_in_exmem     (alu_result_in_exmem),
        .write_data_in_exmem     (write_data_in_exmem),
        .Rd_in_exmem             (Rd_in_exmem),
        .opcode_in_exmem         (opcode_in_exmem),
        .reg_write_en_in_exmem   (reg_write_en_in_exmem),
        .mem_read_en_in_exmem    (mem_read_en_in_exmem),
        .mem_write_en_in_exmem   (mem_write_en_in_exmem),
        .mem_to_reg_in_exmem     (mem_to_reg_in_exmem),
        .mem_size_in_exmem       (mem_size_in_exmem),
        .mem_signed_in_exmem     (mem_signed_in_exmem),
        .stall_out               (stall_out),
        .dmem_req                (dmem_req),
        .dmem_we                 (dmem_we),
        .dmem_addr               (dmem_addr),
        .dmem_be                 (dmem_be),
        .dmem_wdata              (dmem_wdata),
        .dmem_ack                (dmem_ack),
        .dmem_rdata              (dmem_rdata),
        .valid_out_memwb         (valid_out_memwb),
        .pc_out_memwb            (pc_out_memwb),
        .alu_result_out_memwb    (alu_result_out_memwb),
        .mem_read_data_out_memwb (mem_read_data_out_memwb),
        .Rd_out_memwb            (Rd_out_memwb),
        .opcode_out_memwb        (opcode_out_memwb),
        .reg_write_en_out_memwb  (reg_write_en_out_memwb),
        .mem_to_reg_out_memwb    (mem_to_reg_out_memwb),
        .fault_out_memwb         (fault_out_memwb)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic present(input logic v, input logic [31:0] alu, input logic [31:0] wd,
                           input logic rd_en, input logic wr_en, input logic [1:0] sz,
                           input logic sg, input logic rwe, input logic [3:0] rdi);
        valid_in_exmem        = v;
        pc_in_exmem           = 32'h1000 + alu;
        alu_result_in_exmem   = alu;
        write_data_in_exmem   = wd;
        mem_read_en_in_exmem  = rd_en;
        mem_write_en_in_exmem = wr_en;
        mem_size_in_exmem     = sz;
        mem_signed_in_exmem   = sg;
        mem_to_reg_in_exmem   = rd_en;
        reg_write_en_in_exmem = rwe;
        Rd_in_exmem           = rdi;
        opcode_in_exmem       = 5'h03;
    endtask

    task automatic bubble();
        present(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 4'h0);
    endtask

    // Present a mem op at the next cycle, ack it after k wait states, then
    // drive a bubble; returns in the cycle the result should sit in MEM/WB.
    task automatic run_mem(input logic [31:0] addr, input logic [1:0] sz, input logic sg,
                           input logic rd_en, input logic wr_en, input logic [31:0] wd,
                           input int k, input logic [31:0] rdata, input logic [3:0] rdi);
        int stalls = 0;
        @(posedge clk); #1;
        enable = 1'b1;
        present(1'b1, addr, wd, rd_en, wr_en, sz, sg, rd_en, rdi);
        #1 if (stall_out) stalls++;
        check("req_idle", dmem_req, 1'b0);
        @(posedge clk); #1;
        check("req_rise", dmem_req, 1'b1);
        for (int i = 0; i < k; i++) begin
            if (stall_out) stalls++;
            @(posedge clk); #1;
        end
        check("req_held", dmem_req, 1'b1);
        obs_addr  = dmem_addr;
        obs_be    = dmem_be;
        obs_wdata = dmem_wdata;
        obs_we    = dmem_we;
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        #1 check("stall_ack", stall_out, 1'b0);
        check("stall_cycles", stalls, k + 1);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        bubble();
    endtask

    initial begin
        reset = 1'b1;
        enable = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        bubble();
        repeat (2) @(posedge clk);
        #1;
        check("rst_stall", stall_out, 1'b0);
        check("rst_req", dmem_req, 1'b0);
        check("rst_be", dmem_be, 4'h0);
        check("rst_valid", valid_out_memwb, 1'b0);
        check("rst_fault", fault_out_memwb, 1'b0);
        check("rst_data", mem_read_data_out_memwb, 32'h0);
        reset = 1'b0;

        // Word load, ack in the third request cycle.
        run_mem(32'h100, 2'b10, 1'b0, 1'b1, 1'b0, 32'h0, 2, 32'hDEADBEEF, 4'h3);
        check("lw_addr", obs_addr, 32'h100);
        check("lw_be", obs_be, 4'hF);
        check("lw_we", obs_we, 1'b0);
        check("lw_valid", valid_out_memwb, 1'b1);
        check("lw_data", mem_read_data_out_memwb, 32'hDEADBEEF);
        check("lw_m2r", mem_to_reg_out_memwb, 1'b1);
        check("lw_rwe", reg_write_en_out_memwb, 1'b1);
        check("lw_rd", Rd_out_memwb, 4'h3);
        check("lw_fault", fault_out_memwb, 1'b0);

        // Byte loads from lane 3, signed and unsigned.
        run_mem(32'h103, 2'b00, 1'b1, 1'b1, 1'b0, 32'h0, 0, 32'h80FF1234, 4'h4);
        check("lbs_addr", obs_addr, 32'h100);
        check("lbs_be", obs_be, 4'b1000);
        check("lbs_data", mem_read_data_out_memwb, 32'hFFFFFF80);
        run_mem(32'h103, 2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 1, 32'h80FF1234, 4'h4);
        check("lbu_data", mem_read_data_out_memwb, 32'h00000080);

        // Signed halfword from the upper half.
        run_mem(32'h102, 2'b01, 1'b1, 1'b1, 1'b0, 32'h0, 0, 32'h80010000, 4'h6);
        check("lhs_be", obs_be, 4'b1100);
        check("lhs_data", mem_read_data_out_memwb, 32'hFFFF8001);

        // Halfword and byte stores.
        run_mem(32'h42, 2'b01, 1'b0, 1'b0, 1'b1, 32'h0000ABCD, 1, 32'h55555555, 4'h0);
        check("sh_addr", obs_addr, 32'h40);
        check("sh_be", obs_be, 4'b1100);
        check("sh_wdata", obs_wdata, 32'hABCDABCD);
        check("sh_we", obs_we, 1'b1);
        check("sh_rwe", reg_write_en_out_memwb, 1'b0);
        check("sh_valid", valid_out_memwb, 1'b1);
        run_mem(32'h41, 2'b00, 1'b0, 1'b0, 1'b1, 32'hFFFFFF77, 0, 32'h0, 4'h0);
        check("sb_be", obs_be, 4'b0010);
        check("sb_wdata", obs_wdata, 32'h77777777);

        // Misaligned word load and illegal dword size fault without a request.
        @(posedge clk); #1;
        present(1'b1, 32'h101, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 4'h2);
        #1 check("mis_stall", stall_out, 1'b0);
        @(posedge clk); #1;
        bubble();
        check("mis_req", dmem_req, 1'b0);
        check("mis_fault", fault_out_memwb, 1'b1);
        check("mis_valid", valid_out_memwb, 1'b1);
        check("mis_rwe", reg_write_en_out_memwb, 1'b0);
        present(1'b1, 32'h108, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0, 1'b1, 4'h2);
        @(posedge clk); #1;
        bubble();
        check("ill_req", dmem_req, 1'b0);
        check("ill_fault", fault_out_memwb, 1'b1);

        // Non-mem op passes straight through, then a bubble clears valid.
        present(1'b1, 32'h12345678, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 4'h5);
        #1 check("alu_stall", stall_out, 1'b0);
        @(posedge clk); #1;
        bubble();
        check("alu_valid", valid_out_memwb, 1'b1);
        check("alu_result", alu_result_out_memwb, 32'h12345678);
        check("alu_rdata", mem_read_data_out_memwb, 32'h0);
        check("alu_rd", Rd_out_memwb, 4'h5);
        check("alu_fault", fault_out_memwb, 1'b0);
        @(posedge clk); #1;
        check("bubble_valid", valid_out_memwb, 1'b0);

        // enable=0 freezes MEM/WB and stalls a valid instruction.
        enable = 1'b0;
        present(1'b1, 32'hAAAA0000, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 4'h9);
        #1 check("frz_stall", stall_out, 1'b1);
        @(posedge clk); #1;
        check("frz_valid", valid_out_memwb, 1'b0);
        bubble();
        enable = 1'b1;

        // Ack while enable=0: result parked in DONE, released exactly once.
        @(posedge clk); #1;
        present(1'b1, 32'h200, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 4'h7);
        @(posedge clk); #1;
        check("dn_req", dmem_req, 1'b1);
        enable     = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        #1 check("dn_stall_ack", stall_out, 1'b1);
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        bubble();
        check("dn_req_drop", dmem_req, 1'b0);
        check("dn_stall", stall_out, 1'b1);
        check("dn_hold0", valid_out_memwb, 1'b0);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h11111111;
        @(posedge clk); #1;
        check("dn_hold1", valid_out_memwb, 1'b0);
        dmem_ack = 1'b0;
        enable   = 1'b1;
        #1 check("dn_stall_en", stall_out, 1'b1);
        @(posedge clk); #1;
        check("dn_valid", valid_out_memwb, 1'b1);
        check("dn_data", mem_read_data_out_memwb, 32'hCAFEF00D);
        check("dn_rd", Rd_out_memwb, 4'h7);
        check("dn_stall_off", stall_out, 1'b0);
        @(posedge clk); #1;
        check("dn_once", valid_out_memwb, 1'b0);
        check("dn_no_req", dmem_req, 1'b0);

        // Reset in the middle of a request.
        present(1'b1, 32'h55, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 4'h1);
        @(posedge clk); #1;
        present(1'b1, 32'h300, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 4'h8);
        @(posedge clk); #1;
        check("rr_req", dmem_req, 1'b1);
        check("rr_valid_pre", valid_out_memwb, 1'b1);
        #2;
        reset = 1'b1;
        bubble();
        #1;
        check("rr_req_drop", dmem_req, 1'b0);
        check("rr_valid", valid_out_memwb, 1'b0);
        check("rr_stall", stall_out, 1'b0);
        check("rr_be", dmem_be, 4'h0);
        @(posedge clk); #1;
        reset      = 1'b0;
        dmem_ack   = 1'b1;
        dmem_rdata = 32'h99999999;
        repeat (2) @(posedge clk);
        #1;
        check("rr_late_valid", valid_out_memwb, 1'b0);
        check("rr_late_data", mem_read_data_out_memwb, 32'h0);
        check("rr_late_req", dmem_req, 1'b0);
        dmem_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
